// File: rtl/slice_config_loader.sv
// rtl/slice_config_loader.sv - streams config words into a shadow vector and commits them to a memory slice
//
// Ports:
//   cclk, rst                 clock (rising edge) and asynchronous active-high reset
//   start, abort              begin a load / cancel a load in progress
//   word_in, word_valid       config word stream; word_ready is high only while loading
//   luts_config_out           LUT truth tables for the slice
//   inter_lut_mux_config_out  inter-LUT mux select bits
//   config_use_cc_out         carry-chain enable
//   cen                       one-cycle capture enable, config outputs already valid
//   busy, done                load/commit in progress; last load completed
module slice_config_loader #(
    parameter  int S_XX_BASE  = 4,
    parameter  int NUM_LUTS   = 4,
    parameter  int WORD_W     = 8,
    localparam int CFG_SIZE   = 2**S_XX_BASE + 1,
    localparam int MUX_LVLS   = $clog2(NUM_LUTS),
    localparam int LUT_BITS   = 2 * CFG_SIZE * NUM_LUTS,
    localparam int TOTAL_BITS = LUT_BITS + MUX_LVLS + 1,
    localparam int NUM_WORDS  = (TOTAL_BITS + WORD_W - 1) / WORD_W
) (
    input  logic                cclk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [WORD_W-1:0]   word_in,
    input  logic                word_valid,
    output logic                word_ready,
    output logic [LUT_BITS-1:0] luts_config_out,
    output logic [MUX_LVLS-1:0] inter_lut_mux_config_out,
    output logic                config_use_cc_out,
    output logic                cen,
    output logic                busy,
    output logic                done
);

    localparam int               CNT_W    = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [TOTAL_BITS-1:0]   shadow, shadow_next;
    logic [TOTAL_BITS-1:0]   word_bits, word_mask;
    logic                    commit_now;

    // Each shadow bit knows at elaboration time which word and which word bit
    // feed it; bits of the final word beyond TOTAL_BITS-1 simply have no lane.
    for (genvar j = 0; j < TOTAL_BITS; j++) begin : g_lane
        assign word_bits[j] = word_in[j % WORD_W];
        assign word_mask[j] = (cnt == CNT_W'(j / WORD_W));
    end

    assign word_ready = (state == LOAD);

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        shadow_next = shadow;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next  = LOAD;
                    cnt_next    = '0;
                    shadow_next = '0;
                end
            end
            LOAD: begin
                // abort takes priority so a word offered alongside it is dropped
                if (abort) begin
                    state_next = IDLE;
                end else if (word_valid) begin
                    shadow_next = (shadow & ~word_mask) | (word_bits & word_mask);
                    cnt_next    = cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_next = COMMIT;
                    end
                end
            end
            COMMIT:  state_next = DONE;
            default: state_next = IDLE;
        endcase
        commit_now = (state == LOAD) && (state_next == COMMIT);
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state                    <= IDLE;
            cnt                      <= '0;
            shadow                   <= '0;
            luts_config_out          <= '0;
            inter_lut_mux_config_out <= '0;
            config_use_cc_out        <= 1'b0;
            cen                      <= 1'b0;
            busy                     <= 1'b0;
            done                     <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            shadow <= shadow_next;
            // Outputs are loaded from shadow_next so the final word lands on
            // the same edge, letting cen see fully updated config.
            if (commit_now) begin
                luts_config_out          <= shadow_next[LUT_BITS-1:0];
                inter_lut_mux_config_out <= shadow_next[LUT_BITS+MUX_LVLS-1:LUT_BITS];
                config_use_cc_out        <= shadow_next[TOTAL_BITS-1];
            end
            cen  <= (state_next == COMMIT);
            busy <= (state_next == LOAD) || (state_next == COMMIT);
            done <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_slice_config_loader.sv
// tb/tb_slice_config_loader.sv - scoreboard testbench for slice_config_loader
module tb_slice_config_loader;

    localparam int WORD_W     = 8;
    localparam int LUT_BITS   = 136;
    localparam int MUX_LVLS   = 2;
    localparam int TOTAL_BITS = 139;
    localparam int NUM_WORDS  = 18;

    logic                cclk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [WORD_W-1:0]   word_in = '0;
    logic                word_valid = 1'b0;
    logic                word_ready;
    logic [LUT_BITS-1:0] luts_config_out;
    logic [MUX_LVLS-1:0] inter_lut_mux_config_out;
    logic                config_use_cc_out;
    logic                cen, busy, done;

    slice_config_loader dut (
        .cclk                     (cclk),
        .rst                      (rst),
        .start                    (start),
        .abort                    (abort),
        .word_in                  (word_in),
        .word_valid               (word_valid),
        .word_ready               (word_ready),
        .luts_config_out          (luts_config_out),
        .inter_lut_mux_config_out (inter_lut_mux_config_out),
        .config_use_cc_out        (config_use_cc_out),
        .cen                      (cen),
        .busy                     (busy),
        .done                     (done)
    );

    always #5 cclk = ~cclk;

    typedef struct {
        logic [LUT_BITS-1:0] luts;
        logic [MUX_LVLS-1:0] mux;
        logic                cc;
    } cfg_t;

    int   checks = 0;
    int   failures = 0;
    int   cen_count = 0;
    int   loads_done = 0;
    logic cen_prev = 1'b0;
    cfg_t exp_q[$];
    cfg_t model;
    logic [WORD_W-1:0] cur_words [NUM_WORDS];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // The config image is simply the words concatenated little-end first,
    // then sliced into fields; anything above bit TOTAL_BITS-1 is padding.
    function automatic cfg_t expected_cfg();
        logic [NUM_WORDS*WORD_W-1:0] full;
        cfg_t r;
        for (int k = 0; k < NUM_WORDS; k++) full[k*WORD_W +: WORD_W] = cur_words[k];
        r.luts = full[LUT_BITS-1:0];
        r.mux  = full[LUT_BITS+MUX_LVLS-1:LUT_BITS];
        r.cc   = full[TOTAL_BITS-1];
        return r;
    endfunction

    // Monitor: every cen pulse must match the oldest expected commit.
    always @(negedge cclk) begin
        if (rst) begin
            cen_prev = 1'b0;
        end else begin
            if (cen) begin
                cfg_t e;
                cen_count++;
                check("cen_single_cycle", cen_prev, 1'b0);
                if (exp_q.size() == 0) begin
                    check("cen_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_luts", luts_config_out, e.luts);
                    check("commit_mux", inter_lut_mux_config_out, e.mux);
                    check("commit_use_cc", config_use_cc_out, e.cc);
                    check("commit_busy", busy, 1'b1);
                end
            end
            cen_prev = cen;
        end
    end

    task automatic check_outputs_model(input string tag);
        check({tag, "_luts"}, luts_config_out, model.luts);
        check({tag, "_mux"}, inter_lut_mux_config_out, model.mux);
        check({tag, "_use_cc"}, config_use_cc_out, model.cc);
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge cclk);
        start = 1'b0;
        check("load_busy", busy, 1'b1);
        check("load_ready", word_ready, 1'b1);
        check("load_done_cleared", done, 1'b0);
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        word_valid = 1'b1;
        word_in    = w;
        @(negedge cclk);
        word_valid = 1'b0;
        word_in    = $urandom;
    endtask

    // gap_mode: 0 back-to-back, 1 idle cycle between words, 2 random idles.
    // start_at >= 0 pulses a stray start before that word index.
    task automatic run_load(input int gap_mode, input int start_at);
        start_load();
        for (int k = 0; k < NUM_WORDS; k++) begin
            int idles;
            idles = (gap_mode == 1 && k > 0) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
            repeat (idles) @(negedge cclk);
            if (k == start_at) begin
                start = 1'b1;
                @(negedge cclk);
                start = 1'b0;
                check("stray_start_busy", busy, 1'b1);
            end
            if (k == NUM_WORDS - 1) begin
                model = expected_cfg();
                exp_q.push_back(model);
                loads_done++;
            end
            send_word(cur_words[k]);
            if (k < NUM_WORDS - 1) check("no_early_cen", cen, 1'b0);
        end
        check("cen_after_last", cen, 1'b1);
        check("commit_ready_low", word_ready, 1'b0);
        @(negedge cclk);
        check("post_cen_low", cen, 1'b0);
        check("post_done", done, 1'b1);
        check("post_busy", busy, 1'b0);
        check_outputs_model("post");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model = '{luts: '0, mux: '0, cc: 1'b0};
        #1 rst = 1'b1;
        #2;
        check_outputs_model("reset");
        check("reset_cen", cen, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ready", word_ready, 1'b0);
        @(negedge cclk);
        rst = 1'b0;
        @(negedge cclk);
        check("idle_ready", word_ready, 1'b0);

        // Counting pattern, back-to-back then with backpressure.
        for (int k = 0; k < NUM_WORDS; k++) cur_words[k] = WORD_W'(k + 1);
        run_load(0, -1);
        check("count_luts_lo", luts_config_out[7:0], 8'h01);
        check("count_luts_hi", luts_config_out[135:128], 8'h11);
        check("count_mux", inter_lut_mux_config_out, 2'b10);
        check("count_use_cc", config_use_cc_out, 1'b0);
        run_load(1, -1);
        check("bp_luts_hi", luts_config_out[135:128], 8'h11);
        check("bp_mux", inter_lut_mux_config_out, 2'b10);

        // All ones: padding bits of the last word must not leak.
        for (int k = 0; k < NUM_WORDS; k++) cur_words[k] = 8'hFF;
        run_load(0, -1);
        check("ones_use_cc", config_use_cc_out, 1'b1);
        check("ones_mux", inter_lut_mux_config_out, 2'b11);
        check("ones_luts", luts_config_out, {LUT_BITS{1'b1}});

        // Abort after five words with a word offered on the abort cycle.
        begin
            int cen_before;
            cen_before = cen_count;
            start_load();
            for (int k = 0; k < 5; k++) send_word(WORD_W'($urandom));
            abort      = 1'b1;
            word_valid = 1'b1;
            word_in    = 8'h00;
            @(negedge cclk);
            abort      = 1'b0;
            word_valid = 1'b0;
            check("abort_busy", busy, 1'b0);
            check("abort_ready", word_ready, 1'b0);
            check("abort_done", done, 1'b0);
            repeat (3) @(negedge cclk);
            check("abort_no_cen", cen_count, cen_before);
            check_outputs_model("abort");
        end

        // Stray start after three words.
        for (int k = 0; k < NUM_WORDS; k++) cur_words[k] = WORD_W'($urandom);
        run_load(0, 3);

        // Asynchronous reset mid-load, asserted between edges.
        start_load();
        for (int k = 0; k < 10; k++) send_word(WORD_W'($urandom));
        #2 rst = 1'b1;
        #1;
        model = '{luts: '0, mux: '0, cc: 1'b0};
        check_outputs_model("async_rst");
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ready", word_ready, 1'b0);
        check("async_rst_done", done, 1'b0);
        @(negedge cclk);
        rst = 1'b0;
        repeat (2) @(negedge cclk);
        check("rst_idle_busy", busy, 1'b0);

        // Random loads with random gaps.
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < NUM_WORDS; k++) cur_words[k] = WORD_W'($urandom);
            run_load(2, -1);
        end

        repeat (2) @(negedge cclk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("cen_total", cen_count, loads_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
